// File: rtl/spi_slave_mode0.sv
//------------------------------------------------------------------------------
// Module   : spi_slave_mode0
// Brief    : SPI mode-0 slave, oversampled in the sys_clk domain. Deserializes
//            MOSI MSB-first into rx_data and serializes a one-deep buffered
//            transmit word onto MISO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_slave_mode0 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  spi_clk,
    input  logic                  spi_csn,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_wr,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_vld,
    output logic                  tx_underrun,
    output logic                  rx_abort,
    output logic                  busy
);

    localparam int                 c_CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic                  r_csn_s1, r_csn_s2, r_csn_s3;
    logic                  r_mosi_s1, r_mosi_s2;

    logic [DATA_WIDTH-1:0] r_tx_buf;
    logic                  r_tx_ready;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic                  r_reload_pending;
    logic                  r_miso;
    logic                  r_rx_vld;
    logic                  r_tx_underrun;
    logic                  r_rx_abort;

    logic                  w_sclk_rise, w_sclk_fall, w_csn_fall, w_csn_rise;
    logic                  w_load, w_tx_shift, w_rx_shift, w_end, w_abort;
    logic                  w_word_done, w_underrun;
    logic [DATA_WIDTH-1:0] w_load_word;

    // Pin synchronizers. CSN stages reset low so that a CSN already held low
    // when reset releases never looks like a fresh select; a spurious rise is
    // harmless because IDLE ignores it.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_csn_s1  <= 1'b0;
            r_csn_s2  <= 1'b0;
            r_csn_s3  <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_sclk_s1 <= spi_clk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_csn_s1  <= spi_csn;
            r_csn_s2  <= r_csn_s1;
            r_csn_s3  <= r_csn_s2;
            r_mosi_s1 <= spi_mosi;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
    assign w_csn_fall  = ~r_csn_s2 & r_csn_s3;
    assign w_csn_rise  = r_csn_s2 & ~r_csn_s3;

    // State register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle datapath controls; CSN rise wins over SCLK edges.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_tx_shift  = 1'b0;
        w_rx_shift  = 1'b0;
        w_end       = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_csn_fall) begin
                    w_state_nxt = ST_ACTIVE;
                    w_load      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_csn_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_end       = 1'b1;
                    w_abort     = (r_bit_cnt != '0);
                end else begin
                    w_rx_shift = w_sclk_rise;
                    if (w_sclk_fall) begin
                        w_load     = r_reload_pending;
                        w_tx_shift = ~r_reload_pending;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_word_done = w_rx_shift && (r_bit_cnt == c_LAST_BIT);

    // Word source for a load: buffered word, else a same-cycle write, else zeros.
    assign w_load_word = !r_tx_ready ? r_tx_buf : (tx_wr ? tx_data : '0);
    assign w_underrun  = w_load & r_tx_ready & ~tx_wr;

    // Transmit buffer, shift registers, bit counter and status pulses.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_tx_buf         <= '0;
            r_tx_ready       <= 1'b1;
            r_tx_shift       <= '0;
            r_rx_shift       <= '0;
            r_rx_data        <= '0;
            r_bit_cnt        <= '0;
            r_reload_pending <= 1'b0;
            r_miso           <= 1'b0;
            r_rx_vld         <= 1'b0;
            r_tx_underrun    <= 1'b0;
            r_rx_abort       <= 1'b0;
        end else begin
            r_rx_vld      <= 1'b0;
            r_tx_underrun <= w_underrun;
            r_rx_abort    <= w_abort;

            // A load consumes a full buffer; a same-cycle write on an empty
            // buffer goes straight to the shifter and is not also buffered.
            if (w_load) begin
                if (!r_tx_ready) begin
                    r_tx_ready <= 1'b1;
                end
            end else if (tx_wr && r_tx_ready) begin
                r_tx_buf   <= tx_data;
                r_tx_ready <= 1'b0;
            end

            if (w_load) begin
                r_tx_shift <= w_load_word;
                r_miso     <= w_load_word[DATA_WIDTH-1];
            end else if (w_tx_shift) begin
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                r_miso     <= r_tx_shift[DATA_WIDTH-2];
            end else if (w_end) begin
                r_miso <= 1'b0;
            end

            if (w_end) begin
                r_rx_shift <= '0;
            end else if (w_rx_shift) begin
                r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], r_mosi_s2};
            end

            if (w_end || (r_state == ST_IDLE)) begin
                r_bit_cnt <= '0;
            end else if (w_rx_shift) begin
                r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + c_CNT_W'(1);
            end

            if (w_word_done) begin
                r_rx_data <= {r_rx_shift[DATA_WIDTH-2:0], r_mosi_s2};
                r_rx_vld  <= 1'b1;
            end

            if (w_end || w_load) begin
                r_reload_pending <= 1'b0;
            end else if (w_word_done) begin
                r_reload_pending <= 1'b1;
            end
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = (r_state == ST_ACTIVE);
    assign busy        = (r_state == ST_ACTIVE);
    assign tx_ready    = r_tx_ready;
    assign rx_data     = r_rx_data;
    assign rx_vld      = r_rx_vld;
    assign tx_underrun = r_tx_underrun;
    assign rx_abort    = r_rx_abort;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_mode0.sv
//------------------------------------------------------------------------------
// Module   : tb_spi_slave_mode0
// Brief    : Directed self-checking bench for spi_slave_mode0 (DATA_WIDTH=8,
//            SCLK half period of 4 sys_clk cycles).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_slave_mode0;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         spi_clk, spi_csn, spi_mosi;
    logic         spi_miso, spi_miso_oe;
    logic [W-1:0] tx_data;
    logic         tx_wr;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_vld, tx_underrun, rx_abort, busy;

    int checks = 0;
    int errors = 0;

    int vld_cnt = 0;
    int un_cnt  = 0;
    int ab_cnt  = 0;
    int vld_wide = 0;
    logic prev_vld = 1'b0;
    logic [W-1:0] vld_q[$];

    spi_slave_mode0 #(.DATA_WIDTH(W)) dut (
        .sys_clk    (clk),
        .rst        (rst),
        .spi_clk    (spi_clk),
        .spi_csn    (spi_csn),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_vld     (rx_vld),
        .tx_underrun(tx_underrun),
        .rx_abort   (rx_abort),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_vld) begin
                vld_cnt++;
                vld_q.push_back(rx_data);
                if (prev_vld) vld_wide++;
            end
            if (tx_underrun) un_cnt++;
            if (rx_abort)    ab_cnt++;
        end
        prev_vld = rx_vld;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic select_slave();
        spi_csn = 1'b0;
        wait_clk(4);
    endtask

    task automatic deselect_slave();
        spi_csn = 1'b1;
        wait_clk(6);
    endtask

    // Clock nbits of a word MSB-first; MISO captured just before each rise.
    task automatic xfer(input logic [W-1:0] mosi_w, input int nbits, output logic [W-1:0] miso_w);
        miso_w = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mosi_w[W-1-i];
            wait_clk(4);
            miso_w[W-1-i] = spi_miso;
            spi_clk = 1'b1;
            wait_clk(4);
            spi_clk = 1'b0;
        end
    endtask

    task automatic write_tx(input logic [W-1:0] d);
        tx_data = d;
        tx_wr   = 1'b1;
        wait_clk(1);
        tx_wr   = 1'b0;
    endtask

    initial begin
        logic [W-1:0] miso_w;
        int un0, vld0, ab0;

        rst = 1'b1; spi_clk = 1'b0; spi_csn = 1'b1; spi_mosi = 1'b0;
        tx_data = '0; tx_wr = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4);

        // Reset state
        chk("rst_miso",     spi_miso,    0);
        chk("rst_oe",       spi_miso_oe, 0);
        chk("rst_rx_data",  rx_data,     0);
        chk("rst_tx_ready", tx_ready,    1);
        chk("rst_busy",     busy,        0);
        chk("rst_pulses",   vld_cnt + un_cnt + ab_cnt, 0);

        // Single byte: TX 0xA5, MOSI 0x55
        write_tx(8'hA5);
        chk("t1_ready_low", tx_ready, 0);
        un0 = un_cnt;
        select_slave();
        chk("t1_busy",      busy,        1);
        chk("t1_oe",        spi_miso_oe, 1);
        chk("t1_ready_hi",  tx_ready,    1);
        chk("t1_no_under",  un_cnt,      un0);
        xfer(8'h55, 8, miso_w);
        chk("t1_miso",      miso_w,      8'hA5);
        chk("t1_rx_data",   rx_data,     8'h55);
        chk("t1_vld_cnt",   vld_cnt,     1);
        deselect_slave();
        chk("t1_oe_off",    spi_miso_oe, 0);
        chk("t1_busy_off",  busy,        0);

        // Two words in one select window
        write_tx(8'h3C);
        select_slave();
        write_tx(8'hC3);
        xfer(8'h12, 8, miso_w);
        chk("t2_miso0",     miso_w,  8'h3C);
        xfer(8'h34, 8, miso_w);
        chk("t2_miso1",     miso_w,  8'hC3);
        deselect_slave();
        chk("t2_vld_cnt",   vld_cnt, 3);
        chk("t2_rx0",       vld_q[1], 8'h12);
        chk("t2_rx1",       vld_q[2], 8'h34);

        // Underrun at select
        un0 = un_cnt;
        select_slave();
        chk("t3_under",     un_cnt,  un0 + 1);
        xfer(8'hE7, 8, miso_w);
        chk("t3_miso",      miso_w,  8'h00);
        chk("t3_rx_data",   rx_data, 8'hE7);
        deselect_slave();

        // Abort after 5 rises
        vld0 = vld_cnt; ab0 = ab_cnt;
        select_slave();
        xfer(8'hFF, 5, miso_w);
        deselect_slave();
        chk("t4_abort",     ab_cnt,  ab0 + 1);
        chk("t4_no_vld",    vld_cnt, vld0);
        chk("t4_rx_keep",   rx_data, 8'hE7);
        chk("t4_oe",        spi_miso_oe, 0);
        chk("t4_busy",      busy,    0);

        // Write while full is dropped
        write_tx(8'h11);
        write_tx(8'h22);
        chk("t5_ready",     tx_ready, 0);
        select_slave();
        chk("t5_ready_hi",  tx_ready, 1);
        xfer(8'h00, 8, miso_w);
        chk("t5_miso",      miso_w,  8'h11);
        deselect_slave();

        // Write coinciding with the select load on an empty buffer
        un0 = un_cnt;
        spi_csn = 1'b0;
        wait_clk(2);
        tx_data = 8'h77;
        tx_wr   = 1'b1;
        wait_clk(1);
        tx_wr   = 1'b0;
        wait_clk(1);
        chk("t6_no_under",  un_cnt,  un0);
        chk("t6_busy",      busy,    1);
        xfer(8'h5A, 8, miso_w);
        chk("t6_miso",      miso_w,  8'h77);
        chk("t6_rx_data",   rx_data, 8'h5A);
        deselect_slave();

        // Reset mid-word, then a clean transfer
        select_slave();
        xfer(8'hFF, 3, miso_w);
        rst = 1'b1;
        #1;
        chk("t7_rst_busy",  busy,        0);
        chk("t7_rst_oe",    spi_miso_oe, 0);
        chk("t7_rst_rx",    rx_data,     0);
        chk("t7_rst_ready", tx_ready,    1);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(6);
        chk("t7_no_resel",  busy,        0);
        deselect_slave();
        vld0 = vld_cnt;
        select_slave();
        chk("t7_busy",      busy,    1);
        xfer(8'h81, 8, miso_w);
        chk("t7_rx_data",   rx_data, 8'h81);
        chk("t7_vld",       vld_cnt, vld0 + 1);
        deselect_slave();

        chk("vld_width",    vld_wide, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
